// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-divider controller.
package clk_div_pkg;
  localparam int CNT_W_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 2;
  localparam int MIN_DIV         = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;
endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered duty-cycle and end-of-period comparators.
// Outputs are registered together with cnt, so they describe the cnt value held in the same cycle.
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             cnt_last,
  output logic             clk_out,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half;
  logic             active;

  // ceil(div/2) without needing a wider adder
  assign half     = div - (div >> 1);
  assign cnt_last = active && (cnt == div - CNT_W'(1));

  // A fresh start or a wrap always lands on 0, where clk_out is high and tick is low for any div >= 2.
  // Elsewhere div cannot change before the next cycle, so the current div is the right one to compare with.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (!active || cnt_last) cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (run) begin
      active  <= 1'b1;
      cnt     <= cnt_nxt;
      clk_out <= (cnt_nxt < half);
      tick    <= (cnt_nxt == div - CNT_W'(1));
    end else begin
      active  <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end
  end
endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: run/stop sequencing and a ratio handshake whose
// new values only take effect at period boundaries, so clk_out never has a runt pulse.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cur_div;
  logic [CNT_W-1:0] pend_div;
  logic             xfer;
  logic             div_ok;
  logic             cnt_last;

  assign xfer   = cfg_valid && cfg_ready;
  assign div_ok = (cfg_div >= CNT_W'(MIN_DIV));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN: begin
        if (cnt_last && !enable)  state_nxt = IDLE;
        else if (xfer && div_ok)  state_nxt = PENDING;
      end
      PENDING: if (cnt_last) state_nxt = enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state != PENDING);
    running   = (state != IDLE);
  end

  // A ratio accepted in the very cycle the divider stops is committed directly,
  // matching the rule that a stop from PENDING commits the held ratio.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_div  <= CNT_W'(DEFAULT_DIV);
      pend_div <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= xfer && !div_ok;
      case (state)
        IDLE: if (xfer && div_ok) cur_div <= cfg_div;
        RUN: begin
          if (xfer && div_ok) begin
            if (cnt_last && !enable) cur_div  <= cfg_div;
            else                     pend_div <= cfg_div;
          end
        end
        PENDING: if (cnt_last) cur_div <= pend_div;
        default: ;
      endcase
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .run      (state_nxt != IDLE),
    .div      (cur_div),
    .cnt_last (cnt_last),
    .clk_out  (clk_out),
    .tick     (tick)
  );
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl against a period-position reference model.
module tb_clk_div_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic       running;

  int checks = 0;
  int errors = 0;

  // Reference model: whether the divider is active, position within the period,
  // current ratio and an optional held ratio waiting for the next boundary.
  int m_cur, m_pend, m_pos;
  bit m_hasp, m_act, m_err;

  always #5 clk = ~clk;

  clk_div_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = 2; m_pend = 0; m_pos = 0;
    m_hasp = 0; m_act = 0; m_err = 0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "clk_out"},   32'(clk_out),   32'(m_act && (m_pos < (m_cur + 1) / 2)));
    chk({pfx, "tick"},      32'(tick),      32'(m_act && (m_pos == m_cur - 1)));
    chk({pfx, "running"},   32'(running),   32'(m_act));
    chk({pfx, "cfg_ready"}, 32'(cfg_ready), 32'(!m_hasp));
    chk({pfx, "cfg_err"},   32'(cfg_err),   32'(m_err));
  endtask

  task automatic model_step(input bit en, input bit v, input int d);
    bit xfer, good, boundary;
    xfer  = v && !m_hasp;
    good  = xfer && (d >= 2);
    m_err = xfer && (d < 2);
    if (!m_act) begin
      if (good) m_cur = d;
      if (en) begin m_act = 1; m_pos = 0; end
    end else begin
      boundary = (m_pos == m_cur - 1);
      if (!boundary) begin
        m_pos++;
        if (good) begin m_pend = d; m_hasp = 1; end
      end else if (m_hasp) begin
        m_cur = m_pend; m_hasp = 0; m_pos = 0; m_act = en;
      end else if (!en) begin
        if (good) m_cur = d;
        m_pos = 0; m_act = 0;
      end else begin
        m_pos = 0;
        if (good) begin m_pend = d; m_hasp = 1; end
      end
    end
  endtask

  initial begin
    bit en_lvl;
    int r;
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    en_lvl = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset_");
    reset = 1'b0;
    check_outputs("release_");

    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst_");
        @(negedge clk);
        reset = 1'b0;
      end
      if ($urandom_range(0, 14) == 0) en_lvl = ~en_lvl;
      enable    = en_lvl;
      cfg_valid = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 19);
      if (r == 0)      cfg_div = 8'd255;
      else if (r == 1) cfg_div = 8'($urandom_range(0, 255));
      else             cfg_div = 8'($urandom_range(0, 9));
      @(posedge clk);
      model_step(enable, cfg_valid, int'(cfg_div));
      @(negedge clk);
      check_outputs("");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
